// File: rtl/if_stage_if.sv
// if_stage_pkg / if_stage_if
//   if_stage_pkg : if_params_t, the {ia_plus_4, ir} payload handed to IF/ID.
//   if_stage_if  : instruction-memory request/acknowledge bus.
//     imem_req   : fetch request, held until acknowledged (master -> slave)
//     imem_addr  : word-aligned fetch address, stable while requesting
//     imem_ack   : request complete, imem_rdata valid this cycle (slave -> master)
//     imem_rdata : instruction word
package if_stage_pkg;
  typedef struct packed {
    logic [31:0] ia_plus_4;
    logic [31:0] ir;
  } if_params_t;
endpackage

interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// if_stage -- MINA2000 instruction fetch.
//   Owns the PC, runs the imem req/ack handshake, and registers
//   {ia_plus_4, ir} + valid toward IF/ID. A one-entry skid absorbs an ack
//   that lands while ID is stalled; a redirect that arrives with a request
//   still outstanding waits (DRAIN) for the old ack before refetching.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   stall_in          : ID cannot accept; outputs hold
//   redirect_in/_pc   : flush and restart fetch at redirect_pc (low bits forced 0)
//   imem              : instruction-memory bus (master side)
//   if_params/if_valid: registered payload and valid; ir is 0 on bubbles
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc,
  if_stage_if.master  imem,
  output if_params_t  if_params,
  output logic        if_valid
);

  typedef enum logic [1:0] {S_REQ, S_SKID, S_DRAIN} state_t;

  localparam logic [31:0] PC_RST = RESET_VECTOR & ~32'h3;

  state_t      r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n;
  logic [31:0] r_addr_q;
  if_params_t  r_skid, w_skid_n;
  if_params_t  w_out_n;
  logic        w_vld_n;

  logic        w_req;
  logic        w_ack;
  logic [31:0] w_rpc;
  logic [31:0] w_pc_inc;

  // Request is dropped only while the skid is occupied; gating with rst_n
  // keeps the bus quiet during reset and ignores any stray ack.
  assign w_req          = rst_n && (r_state != S_SKID);
  assign w_ack          = w_req && imem.imem_ack;
  assign imem.imem_req  = w_req;
  // DRAIN must keep presenting the abandoned address until its ack.
  assign imem.imem_addr = (r_state == S_DRAIN) ? r_addr_q : r_pc;

  assign w_rpc    = redirect_pc & ~32'h3;
  assign w_pc_inc = r_pc + 32'd4;

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_skid_n  = r_skid;
    w_out_n   = '0;
    w_vld_n   = 1'b0;
    case (r_state)
      S_REQ: begin
        if (w_ack) begin
          if (redirect_in) begin
            w_pc_n = w_rpc;  // wrong-path data, drop it
          end else begin
            w_pc_n = w_pc_inc;
            if (stall_in) begin
              w_skid_n  = {w_pc_inc, imem.imem_rdata};
              w_state_n = S_SKID;
            end else begin
              w_out_n = {w_pc_inc, imem.imem_rdata};
              w_vld_n = 1'b1;
            end
          end
        end else if (redirect_in) begin
          w_pc_n    = w_rpc;
          w_state_n = S_DRAIN;
        end
      end
      S_SKID: begin
        if (redirect_in) begin
          w_skid_n  = '0;
          w_pc_n    = w_rpc;
          w_state_n = S_REQ;
        end else if (!stall_in) begin
          w_out_n   = r_skid;
          w_vld_n   = 1'b1;
          w_state_n = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_in) w_pc_n = w_rpc;  // latest redirect wins
        if (w_ack)       w_state_n = S_REQ;
      end
      default: w_state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_REQ;
      r_pc     <= PC_RST;
      r_addr_q <= PC_RST;
      r_skid   <= '0;
    end else begin
      r_state  <= w_state_n;
      r_pc     <= w_pc_n;
      // Snapshot of the address in flight; frozen while draining.
      r_addr_q <= (r_state == S_DRAIN) ? r_addr_q : r_pc;
      r_skid   <= w_skid_n;
    end
  end

  // Redirect flushes the output even under stall; w_out_n is already a
  // bubble whenever redirect_in is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_params <= '0;
      if_valid  <= 1'b0;
    end else if (redirect_in || !stall_in) begin
      if_params <= w_out_n;
      if_valid  <= w_vld_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- two if_stage instances (RESET_VECTOR 0 and 0x100), each with
// a memory model returning addr ^ A5A5_0000 after a programmable number of
// wait cycles. Expected deliveries go into a shared scoreboard; per-instance
// monitors pop on every accepted output (valid && !stall) and also watch
// handshake stability and the bubble encoding.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;

  typedef struct {
    int          dut;
    logic [31:0] ia4;
    logic [31:0] ir;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n, stall, redir, mem_en;
  logic [31:0] rpc   [2];
  int          waits [2];

  logic        req_o   [2];
  logic        valid_o [2];
  logic [31:0] addr_o  [2];
  if_params_t  par_o   [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [31:0] ia4, input logic [31:0] ir);
    exp_t e;
    e.dut = d; e.ia4 = ia4; e.ir = ir;
    sb.push_back(e);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_d
    if_stage_if bus();
    if_params_t par;
    logic       vld;
    int         cnt;

    if_stage #(.RESET_VECTOR((g == 0) ? 32'h0 : 32'h100)) dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .stall_in   (stall[g]),
      .redirect_in(redir[g]),
      .redirect_pc(rpc[g]),
      .imem       (bus.master),
      .if_params  (par),
      .if_valid   (vld)
    );

    assign bus.imem_ack   = rst_n[g] && bus.imem_req && mem_en[g] && (cnt >= waits[g]);
    assign bus.imem_rdata = bus.imem_addr ^ K;

    always @(posedge clk or negedge rst_n[g])
      if (!rst_n[g])                                   cnt <= 0;
      else if (!bus.imem_req || !mem_en[g] || bus.imem_ack) cnt <= 0;
      else                                             cnt <= cnt + 1;

    assign req_o[g]   = bus.imem_req;
    assign addr_o[g]  = bus.imem_addr;
    assign valid_o[g] = vld;
    assign par_o[g]   = par;

    // Pre-edge snapshot for the monitor.
    logic        p_v, p_s, p_req, p_ack, p_rst;
    logic [31:0] p_addr;
    if_params_t  p_par;
    always @(posedge clk) begin
      p_v    <= vld;
      p_s    <= stall[g];
      p_par  <= par;
      p_req  <= bus.imem_req;
      p_ack  <= bus.imem_ack;
      p_addr <= bus.imem_addr;
      p_rst  <= rst_n[g];
    end

    exp_t e;
    always @(posedge clk) begin
      #1;
      if (p_rst && rst_n[g]) begin
        if (p_v && !p_s) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut%0d_unexpected_output actual=%h required=none", g, p_par);
          end else begin
            e = sb.pop_front();
            chk($sformatf("dut%0d_out_owner", g), 64'(g), 64'(e.dut));
            chk($sformatf("dut%0d_out_params", g), {p_par.ia_plus_4, p_par.ir}, {e.ia4, e.ir});
          end
        end
        if (!vld) chk($sformatf("dut%0d_bubble_ir", g), 64'(par.ir), 64'd0);
        if (p_req && !p_ack) begin
          chk($sformatf("dut%0d_req_held", g), 64'(bus.imem_req), 64'd1);
          chk($sformatf("dut%0d_addr_held", g), 64'(bus.imem_addr), 64'(p_addr));
        end
      end
    end
  end

  initial begin
    rst_n = '0; stall = '0; redir = '0; mem_en = '0;
    rpc[0] = '0; rpc[1] = '0; waits[0] = 0; waits[1] = 0;
    repeat (2) @(negedge clk);

    // Reset state
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 64'(valid_o[d]), 64'd0);
      chk("rst_params", par_o[d], 64'd0);
      chk("rst_req", 64'(req_o[d]), 64'd0);
    end

    // Zero-wait stream from reset: 3 instructions back to back
    push(0, 32'h4, 32'h0 ^ K);
    push(0, 32'h8, 32'h4 ^ K);
    push(0, 32'hC, 32'h8 ^ K);
    rst_n[0] = 1'b1; mem_en[0] = 1'b1;
    #1;
    chk("t1_req_after_release", 64'(req_o[0]), 64'd1);
    chk("t1_addr_after_release", 64'(addr_o[0]), 64'h0);
    @(negedge clk);
    chk("t1_valid_cycle2", 64'(valid_o[0]), 64'd1);
    repeat (2) @(negedge clk);
    mem_en[0] = 1'b0;
    drain("t1_drain");

    // Stall across an ack: skid holds one, outputs hold, no dup/loss
    push(0, 32'h10, 32'hC ^ K);
    mem_en[0] = 1'b1;
    @(negedge clk);
    stall[0] = 1'b1;
    @(negedge clk);
    chk("t3_skid_req", 64'(req_o[0]), 64'd0);
    chk("t3_hold_params", par_o[0], {32'h10, 32'hC ^ K});
    chk("t3_hold_valid", 64'(valid_o[0]), 64'd1);
    @(negedge clk);
    chk("t3_hold_params2", par_o[0], {32'h10, 32'hC ^ K});
    chk("t3_skid_req2", 64'(req_o[0]), 64'd0);
    @(negedge clk);
    stall[0] = 1'b0; mem_en[0] = 1'b0;
    push(0, 32'h14, 32'h10 ^ K);
    drain("t3_drain");
    chk("t3_next_addr", 64'(addr_o[0]), 64'h14);

    // Redirect while in SKID under stall: skid dropped
    stall[0] = 1'b1; mem_en[0] = 1'b1;
    @(negedge clk);
    chk("t5_in_skid", 64'(req_o[0]), 64'd0);
    mem_en[0] = 1'b0; redir[0] = 1'b1; rpc[0] = 32'h3003;
    @(negedge clk);
    redir[0] = 1'b0; stall[0] = 1'b0;
    chk("t5_valid", 64'(valid_o[0]), 64'd0);
    chk("t5_ir", 64'(par_o[0].ir), 64'd0);
    chk("t5_addr", 64'(addr_o[0]), 64'h3000);
    chk("t5_req", 64'(req_o[0]), 64'd1);
    repeat (2) @(negedge clk);

    // Redirect with no ack: drain old request, then fetch target
    redir[0] = 1'b1; rpc[0] = 32'h40;
    @(negedge clk);
    redir[0] = 1'b0;
    chk("t4_drain_addr", 64'(addr_o[0]), 64'h3000);
    mem_en[0] = 1'b1; waits[0] = 0;
    @(negedge clk);
    chk("t4_addr40_a", 64'(addr_o[0]), 64'h40);
    waits[0] = 3;
    @(negedge clk);
    redir[0] = 1'b1; rpc[0] = 32'h2000;
    chk("t4_addr40_b", 64'(addr_o[0]), 64'h40);
    @(negedge clk);
    redir[0] = 1'b0;
    chk("t4_addr40_c", 64'(addr_o[0]), 64'h40);
    @(negedge clk);
    chk("t4_addr40_d", 64'(addr_o[0]), 64'h40);
    @(negedge clk);
    chk("t4_addr2000", 64'(addr_o[0]), 64'h2000);
    chk("t4_req2000", 64'(req_o[0]), 64'd1);
    chk("t4_no_valid", 64'(valid_o[0]), 64'd0);
    mem_en[0] = 1'b0;
    repeat (2) @(negedge clk);

    // PC wrap, then async reset mid-request
    redir[0] = 1'b1; rpc[0] = 32'hFFFF_FFFC; mem_en[0] = 1'b1; waits[0] = 0;
    @(negedge clk);
    redir[0] = 1'b0;
    chk("t6_addr_top", 64'(addr_o[0]), 64'hFFFF_FFFC);
    push(0, 32'h0, 32'hFFFF_FFFC ^ K);
    @(negedge clk);
    chk("t6_wrap_addr", 64'(addr_o[0]), 64'h0);
    chk("t6_wrap_ia4", 64'(par_o[0].ia_plus_4), 64'h0);
    @(negedge clk);
    stall[0] = 1'b1; mem_en[0] = 1'b0;
    chk("t6_params", par_o[0], {32'h4, 32'h0 ^ K});
    chk("t6_addr4", 64'(addr_o[0]), 64'h4);
    @(negedge clk);
    chk("t6_held_valid", 64'(valid_o[0]), 64'd1);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("t6_async_valid", 64'(valid_o[0]), 64'd0);
    chk("t6_async_params", par_o[0], 64'd0);
    chk("t6_async_req", 64'(req_o[0]), 64'd0);
    @(negedge clk);
    rst_n[0] = 1'b1; stall[0] = 1'b0;
    #1;
    chk("t6_rv_addr", 64'(addr_o[0]), 64'h0);
    chk("t6_rv_req", 64'(req_o[0]), 64'd1);
    drain("t6_drain");

    // Two wait states, RESET_VECTOR 0x100
    push(1, 32'h104, 32'h100 ^ K);
    rst_n[1] = 1'b1; mem_en[1] = 1'b1; waits[1] = 2;
    #1;
    chk("t2_addr_c0", 64'(addr_o[1]), 64'h100);
    @(negedge clk);
    chk("t2_addr_c1", 64'(addr_o[1]), 64'h100);
    chk("t2_bubble_c1", 64'(valid_o[1]), 64'd0);
    @(negedge clk);
    chk("t2_addr_c2", 64'(addr_o[1]), 64'h100);
    chk("t2_bubble_c2", {31'd0, valid_o[1], par_o[1].ir}, 64'd0);
    @(negedge clk);
    chk("t2_out", par_o[1], {32'h104, 32'h100 ^ K});
    chk("t2_valid", 64'(valid_o[1]), 64'd1);
    chk("t2_next_addr", 64'(addr_o[1]), 64'h104);
    mem_en[1] = 1'b0;
    drain("t2_drain");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the MINA2000 pipeline. It owns the program counter, runs a request/acknowledge handshake with the instruction memory port, and delivers `if_params_t` (`ia_plus_4`, `ir`) plus a valid flag to the IF/ID register. It absorbs back-pressure from ID through a one-entry skid buffer. It also handles control-flow redirects from later stages, including redirects that arrive while a memory request is still outstanding.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset. Bits [1:0] are ignored.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `stall_in`  in  1  ID cannot accept a new instruction; outputs hold.
- `redirect_in`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  redirect target. Bits [1:0] are forced to 0.
- `imem_req`  out  1  fetch request; held high until acknowledged.
- `imem_addr`  out  32  fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1  request complete; `imem_rdata` is valid this cycle. May be asserted in the same cycle as `imem_req` (zero wait).
- `imem_rdata`  in  32  instruction word.
- `if_params`  out  if_params_t  registered `{ia_plus_4, ir}` to IF/ID.
- `if_valid`  out  1  `if_params` holds a real instruction. When low, `ir` is 0 (bubble).

## Operation
Registers:
- `pc`: next fetch address.
- `addr_q`: address of the outstanding request.
- `skid`: holds `{ia_plus_4, ir}`.
- `state`: one of REQ, SKID, DRAIN.
- Output registers: `if_params`, `if_valid`.

Reset (async assert):
- `pc`, `addr_q` ← RESET_VECTOR & ~3.
- `state` ← REQ.
- `if_params` ← 0, `if_valid` ← 0, `skid` ← 0.
- `imem_req` is decoded combinationally from `state` and `rst_n`. It is 0 during reset and 1 in the first cycle after release.

Output update rule:
- A redirect always forces `if_valid` ← 0 and `ir` ← 0, regardless of stall.
- Otherwise the outputs load only when `stall_in` = 0.

State REQ (`imem_req` = 1, `imem_addr` = `pc`; `addr_q` tracks `pc`):
- Ack with redirect: discard the data; `pc` ← `redirect_pc`; stay in REQ.
- Ack, no redirect, no stall: outputs ← {`pc`+4, `imem_rdata`}, valid 1; `pc` ← `pc`+4; stay in REQ.
- Ack, no redirect, stall: `skid` ← {`pc`+4, `imem_rdata`}; `pc` ← `pc`+4; go to SKID. Outputs hold.
- No ack with redirect: `pc` ← `redirect_pc`; go to DRAIN. `addr_q` keeps the old address.
- No ack, no redirect: if no stall, output a bubble; stay in REQ.

State SKID (`imem_req` = 0):
- Redirect: drop `skid`; `pc` ← `redirect_pc`; go to REQ.
- No stall: outputs ← `skid`, valid 1; go to REQ.
- Stall: hold.

State DRAIN (`imem_req` = 1, `imem_addr` = `addr_q`):
- Redirect: `pc` ← `redirect_pc`. The latest redirect wins.
- Ack: discard `imem_rdata`; go to REQ.
- Outputs are bubbles (when not stalled).

Arithmetic:
- `pc`+4 is 32-bit and wraps modulo 2^32. For example, FFFF_FFFC+4 = 0000_0000.

## Timing
- Fetch-to-output latency: the ack in cycle N appears on `if_params` in cycle N+1.
- Zero-wait memory sustains 1 instruction per cycle.
- Memory with W wait states yields 1 instruction per W+1 cycles, with bubbles in between.
- Redirect in cycle N (REQ, or SKID with no outstanding request): `imem_addr` = target in cycle N+1.
- Redirect in REQ without ack: the first target request goes out the cycle after the old request's ack.
- A stall never drops an instruction. At most one instruction is buffered, and no new request is issued while SKID is occupied.
- `imem_req` never deasserts before ack, and `imem_addr` never changes before ack.
- Reset asserted mid-request: everything clears immediately. The in-flight ack is the memory side's responsibility; `if_stage` ignores `imem_ack` while in reset.

## Test plan
- Reset release, zero-wait memory returning `addr ^ 32'hA5A5_0000` → `if_valid` high from cycle 2. Successive `ia_plus_4` = 4, 8, C; `ir` matches each address.
- Ack 2 cycles after request, RESET_VECTOR = 32'h100 → `imem_addr` = 100 held for 3 cycles. Outputs are bubbles (`ir` = 0, valid 0), then {104, data}.
- Stall asserted for 3 cycles while ack arrives → SKID entered and `imem_req` = 0. Outputs hold their prior value. On stall release, outputs = {pc+4, skidded data}, with no duplicate and no loss.
- Redirect to 32'h2000 while a request to 40 waits 3 cycles → `imem_addr` stays 40 until ack. Data from 40 never reaches the outputs. Next request is 2000.
- Redirect to 32'h3003 while in SKID with stall high → skid dropped, `if_valid` = 0, next `imem_addr` = 3000.
- `pc` = FFFF_FFFC with zero-wait memory → `ia_plus_4` = 0 and the next fetch is at 0. Then assert `rst_n` low mid-request → outputs clear asynchronously, and `imem_addr` = RESET_VECTOR after release.
